// File: rtl/fofb_readout_sequencer_if.sv
// Port bundle for the FOFB readout sequencer: CSR access, gather status and DSP readout address/present.
// missingBitmap exists only when FOFB_READOUT_MISSING_BITMAP_EN is defined.
interface fofb_readout_sequencer_if #(
  parameter int W = 8
);
  logic            csrStrobe;
  logic [31:0]     GPIO_OUT;
  logic [31:0]     csr;
  logic            FAstrobe;
  logic            readoutValid;
  logic            readTimeout;
  logic            fofbDSPreadoutPresent;
  logic [W-1:0]    fofbDSPreadoutAddress;
  logic            sweepActive;
  logic            sweepDone;
  logic [W-1:0]    presentCount;
  logic            overrun;
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
  logic [2**W-1:0] missingBitmap;
`endif

  modport master (
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
    input  missingBitmap,
`endif
    output csrStrobe, GPIO_OUT, FAstrobe, readoutValid, readTimeout, fofbDSPreadoutPresent,
    input  csr, fofbDSPreadoutAddress, sweepActive, sweepDone, presentCount, overrun
  );

  modport slave (
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
    output missingBitmap,
`endif
    input  csrStrobe, GPIO_OUT, FAstrobe, readoutValid, readTimeout, fofbDSPreadoutPresent,
    output csr, fofbDSPreadoutAddress, sweepActive, sweepDone, presentCount, overrun
  );
endinterface

// File: rtl/fofb_readout_sequencer.sv
// Sweeps the FOFB DSP readout address 0..N-1 after each FA gather, counting present BPMs and flagging overruns.
// Optional FOFB_READOUT_MISSING_BITMAP_EN adds a per-address missing bitmap published with presentCount.
module fofb_readout_sequencer #(
  parameter int FOFB_INDEX_WIDTH = 8,
  parameter int DELAY_WIDTH      = 6
) (
  input  logic                    sysClk,
  input  logic                    sysReset,
  fofb_readout_sequencer_if.slave bus
);
  localparam int W  = FOFB_INDEX_WIDTH;
  localparam int DW = DELAY_WIDTH;
  localparam logic [W-1:0]  PARK   = {W{1'b1}};
  localparam logic [W-1:0]  MAX_N  = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]  ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] ONE_DW = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, WAIT, DELAY, SWEEP, DRAIN, ABORT} state_t;
  state_t state, next_state;

  logic [W-1:0]  bpm_count, cur_n, address, present_count, cfg_n;
  logic [DW-1:0] start_delay, cur_delay, delay_cnt;
  logic          enable, overrun, timed_out_last, sweep_active, sweep_done;
  logic [W:0]    acc, drain_sum;
  logic          trigger, abort, last_addr, unused_gpio;
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
  logic [2**W-1:0] bm_acc, missing_bitmap;
`endif

  assign trigger     = bus.readoutValid || bus.readTimeout;
  assign last_addr   = (address == cur_n - ONE);
  assign drain_sum   = acc + {{W{1'b0}}, bus.fofbDSPreadoutPresent};
  assign cfg_n       = (bus.GPIO_OUT[W-1:0] > MAX_N) ? MAX_N : bus.GPIO_OUT[W-1:0];
  assign unused_gpio = ^bus.GPIO_OUT;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      IDLE:  if (bus.FAstrobe && enable) next_state = WAIT;
      WAIT:  if (bus.FAstrobe) abort = 1'b1;
             else if (trigger) next_state = (cur_n == '0) ? IDLE : DELAY;
      DELAY: if (bus.FAstrobe) abort = 1'b1;
             else if (delay_cnt == '0) next_state = SWEEP;
      SWEEP: if (bus.FAstrobe) abort = 1'b1;
             else if (last_addr) next_state = DRAIN;
      // A strobe landing on DRAIN opens the next FA cycle instead of aborting this one
      DRAIN: next_state = (bus.FAstrobe && enable) ? WAIT : IDLE;
      ABORT: begin
        next_state = WAIT;
        abort      = bus.FAstrobe;
      end
      default: next_state = IDLE;
    endcase
    if (abort) next_state = ABORT;
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      bpm_count      <= '0;
      start_delay    <= '0;
      enable         <= 1'b0;
      overrun        <= 1'b0;
      cur_n          <= '0;
      cur_delay      <= '0;
      delay_cnt      <= '0;
      address        <= PARK;
      sweep_active   <= 1'b0;
      sweep_done     <= 1'b0;
      present_count  <= '0;
      acc            <= '0;
      timed_out_last <= 1'b0;
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
      bm_acc         <= '0;
      missing_bitmap <= '0;
`endif
    end else begin
      sweep_done   <= 1'b0;
      sweep_active <= (next_state == SWEEP);

      if (bus.csrStrobe) begin
        bpm_count   <= cfg_n;
        start_delay <= bus.GPIO_OUT[16 +: DW];
        enable      <= bus.GPIO_OUT[30];
        if (bus.GPIO_OUT[31]) overrun <= 1'b0;
      end
      if (abort) overrun <= 1'b1;

      // Config written mid-sweep only applies from the next WAIT entry
      if (next_state == WAIT && state != WAIT) begin
        cur_n     <= bpm_count;
        cur_delay <= start_delay;
      end

      if (next_state != SWEEP) address <= PARK;
      else if (state == SWEEP) address <= address + ONE;
      else                     address <= '0;

      case (state)
        WAIT: if (!abort && trigger) begin
          timed_out_last <= bus.readTimeout && !bus.readoutValid;
          delay_cnt      <= cur_delay;
          if (cur_n == '0) begin
            sweep_done     <= 1'b1;
            present_count  <= '0;
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
            missing_bitmap <= '0;
`endif
          end
        end
        DELAY: begin
          acc <= '0;
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
          bm_acc <= '0;
`endif
          if (delay_cnt != '0) delay_cnt <= delay_cnt - ONE_DW;
        end
        // Present on this cycle belongs to the address issued one cycle earlier
        SWEEP: if (address != '0) begin
          acc <= drain_sum;
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
          bm_acc[address - ONE] <= !bus.fofbDSPreadoutPresent;
`endif
        end
        DRAIN: begin
          sweep_done    <= 1'b1;
          present_count <= (drain_sum > {1'b0, PARK}) ? PARK : drain_sum[W-1:0];
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
          missing_bitmap <= bm_acc |
                            ({{(2**W-1){1'b0}}, !bus.fofbDSPreadoutPresent} << (cur_n - ONE));
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.fofbDSPreadoutAddress = address;
  assign bus.sweepActive           = sweep_active;
  assign bus.sweepDone             = sweep_done;
  assign bus.presentCount          = present_count;
  assign bus.overrun               = overrun;
  assign bus.csr = {sweep_active, overrun, enable, timed_out_last, 4'b0,
                    8'(present_count), 8'b0, 8'(bpm_count)};
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
  assign bus.missingBitmap = missing_bitmap;
`endif
endmodule

// File: tb/tb_fofb_readout_sequencer.sv
// Directed + randomized bench for fofb_readout_sequencer; expected sweeps come from a simple
// address-list / present-pattern model kept here.
module tb_fofb_readout_sequencer;
  logic sysClk = 1'b0;
  logic sysReset;
  fofb_readout_sequencer_if #(.W(8)) bus();

  fofb_readout_sequencer #(.FOFB_INDEX_WIDTH(8), .DELAY_WIDTH(6)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .bus(bus));

  initial forever #5 sysClk = ~sysClk;

  int tests = 0;
  int fails = 0;
  bit pat [0:255];
  logic [7:0] addr_seq [$];
  int done_cnt, act_cnt;
  int model_cnt = 0;
  bit exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge sysClk); #1; end
  endtask

  function automatic logic [31:0] cfg(input int n, input int d, input bit en, input bit clr);
    logic [31:0] w;
    w = '0; w[7:0] = n[7:0]; w[21:16] = d[5:0]; w[30] = en; w[31] = clr;
    return w;
  endfunction

  task automatic csr_write(input logic [31:0] w);
    bus.csrStrobe = 1'b1; bus.GPIO_OUT = w;
    tick(1);
    bus.csrStrobe = 1'b0;
  endtask

  task automatic mon_clear();
    addr_seq.delete(); done_cnt = 0; act_cnt = 0;
  endtask

  task automatic rand_pat();
    for (int k = 0; k < 256; k++) pat[k] = 1'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (bus.sweepDone) ok = 1'b1;
    end
  endtask

  task automatic wait_addr(input logic [7:0] a, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (bus.fofbDSPreadoutAddress == a) ok = 1'b1;
    end
  endtask

  function automatic int model_count(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(pat[k]);
    return c;
  endfunction

  // Present bit for the address issued on the previous cycle; junk while parked
  initial begin
    logic [7:0] addr_q = 8'hFF;
    forever begin
      @(posedge sysClk); #2;
      bus.fofbDSPreadoutPresent = (addr_q != 8'hFF) ? pat[addr_q] : 1'($urandom);
      addr_q = bus.fofbDSPreadoutAddress;
    end
  end

  initial begin
    forever begin
      @(posedge sysClk); #3;
      if (addr_seq.size() == 0 || addr_seq[$] != bus.fofbDSPreadoutAddress)
        addr_seq.push_back(bus.fofbDSPreadoutAddress);
      if (bus.sweepDone) done_cnt++;
      if (bus.sweepActive) act_cnt++;
    end
  end

  task automatic run_sweep(input int cfg_n, input int n, input int dly, input bit use_v, input bit use_t);
    int lat, exp_cnt;
    bit ok;
    logic [7:0] exp_a;
    logic [31:0] exp_csr;
    logic [255:0] exp_bm;
    csr_write(cfg(cfg_n, dly, 1'b1, 1'b0));
    mon_clear();
    bus.FAstrobe = 1'b1; tick(1); bus.FAstrobe = 1'b0;
    tick(10);
    bus.readoutValid = use_v; bus.readTimeout = use_t;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < dly + 10 && !ok; i++) begin
      tick(1); lat++;
      if (bus.fofbDSPreadoutAddress == 8'h00) ok = 1'b1;
    end
    check("first_addr_latency", lat, dly + 2);
    wait_done(n + 20, ok);
    check("sweep_done_seen", ok, 1);
    bus.readoutValid = 1'b0; bus.readTimeout = 1'b0;
    tick(2);
    exp_cnt = model_count(n);
    model_cnt = exp_cnt;
    check("present_count", bus.presentCount, exp_cnt);
    check("done_pulses", done_cnt, 1);
    check("active_cycles", act_cnt, n);
    check("seq_len", addr_seq.size(), n + 2);
    if (addr_seq.size() == n + 2)
      for (int k = 0; k < n + 2; k++) begin
        exp_a = (k == 0 || k == n + 1) ? 8'hFF : 8'(k - 1);
        check("seq_addr", addr_seq[k], exp_a);
      end
    exp_csr = {1'b0, exp_ovr, 1'b1, use_t && !use_v, 4'b0, 8'(exp_cnt), 8'b0, 8'(n)};
    check("csr_after_sweep", bus.csr, exp_csr);
    exp_bm = '0;
    for (int k = 0; k < n; k++) exp_bm[k] = !pat[k];
`ifdef FOFB_READOUT_MISSING_BITMAP_EN
    check("missing_bitmap", bus.missingBitmap, exp_bm);
`endif
  endtask

  initial begin
    bit ok;
    int n, d, sel;
    bus.csrStrobe = 1'b0; bus.GPIO_OUT = '0; bus.FAstrobe = 1'b0;
    bus.readoutValid = 1'b0; bus.readTimeout = 1'b0; bus.fofbDSPreadoutPresent = 1'b0;
    sysReset = 1'b1;
    tick(3);
    sysReset = 1'b0;
    tick(1);
    check("rst_addr", bus.fofbDSPreadoutAddress, 8'hFF);
    check("rst_active", bus.sweepActive, 0);
    check("rst_done", bus.sweepDone, 0);
    check("rst_count", bus.presentCount, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_csr", bus.csr, 0);

    // Basic sweeps, fixed pattern, timeout-only and both-high triggers
    rand_pat();
    run_sweep(4, 4, 0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) pat[k] = (k == 0 || k == 2 || k == 3);
    run_sweep(5, 5, 0, 1'b1, 1'b0);
    check("fixed_count3", bus.presentCount, 3);
    rand_pat(); run_sweep(6, 6, 2, 1'b0, 1'b1);
    rand_pat(); run_sweep(6, 6, 0, 1'b1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 20); d = $urandom_range(0, 5); sel = $urandom_range(0, 2);
      rand_pat();
      run_sweep(n, n, d, sel != 1, sel != 0);
    end

    // Overrun: strobe while address 2 of 8 is issued
    rand_pat();
    csr_write(cfg(8, 1, 1'b1, 1'b0));
    mon_clear();
    bus.FAstrobe = 1'b1; tick(1); bus.FAstrobe = 1'b0;
    tick(3);
    bus.readoutValid = 1'b1;
    wait_addr(8'h02, 30, ok);
    check("reach_addr2", ok, 1);
    bus.FAstrobe = 1'b1; bus.readoutValid = 1'b0;
    tick(1);
    bus.FAstrobe = 1'b0;
    exp_ovr = 1'b1;
    check("abort_park", bus.fofbDSPreadoutAddress, 8'hFF);
    check("abort_active", bus.sweepActive, 0);
    check("abort_overrun", bus.overrun, 1);
    tick(5);
    check("abort_no_done", done_cnt, 0);
    check("abort_count_kept", bus.presentCount, model_cnt);
    bus.readoutValid = 1'b1;
    wait_done(40, ok);
    check("rearm_done", ok, 1);
    bus.readoutValid = 1'b0;
    tick(2);
    model_cnt = model_count(8);
    check("rearm_count", bus.presentCount, model_cnt);
    check("overrun_sticky", bus.csr[30], 1);
    csr_write(cfg(8, 1, 1'b1, 1'b1));
    exp_ovr = 1'b0;
    check("overrun_cleared", bus.overrun, 0);

    // Strobe on the DRAIN cycle completes the sweep and re-arms without overrun
    rand_pat();
    csr_write(cfg(3, 0, 1'b1, 1'b0));
    mon_clear();
    bus.FAstrobe = 1'b1; tick(1); bus.FAstrobe = 1'b0;
    tick(2);
    bus.readoutValid = 1'b1;
    wait_addr(8'h02, 20, ok);
    check("reach_last_addr", ok, 1);
    tick(1);
    bus.FAstrobe = 1'b1; bus.readoutValid = 1'b0;
    tick(1);
    bus.FAstrobe = 1'b0;
    model_cnt = model_count(3);
    check("drain_strobe_done", bus.sweepDone, 1);
    check("drain_strobe_overrun", bus.overrun, 0);
    check("drain_strobe_count", bus.presentCount, model_cnt);
    tick(3);
    bus.readoutValid = 1'b1;
    wait_done(20, ok);
    check("drain_rearm_done", ok, 1);
    bus.readoutValid = 1'b0;
    tick(2);

    // N = 0: done one cycle after valid, no address issued
    csr_write(cfg(0, 0, 1'b1, 1'b0));
    mon_clear();
    bus.FAstrobe = 1'b1; tick(1); bus.FAstrobe = 1'b0;
    tick(3);
    bus.readoutValid = 1'b1;
    tick(1);
    check("n0_done", bus.sweepDone, 1);
    bus.readoutValid = 1'b0;
    tick(1);
    check("n0_done_pulse", bus.sweepDone, 0);
    tick(2);
    check("n0_seq_len", addr_seq.size(), 1);
    check("n0_count", bus.presentCount, 0);
    check("n0_done_cnt", done_cnt, 1);

    // Clamp: 255 becomes 254
    rand_pat();
    run_sweep(255, 254, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-sweep
    rand_pat();
    csr_write(cfg(6, 0, 1'b1, 1'b0));
    bus.FAstrobe = 1'b1; tick(1); bus.FAstrobe = 1'b0;
    tick(2);
    bus.readoutValid = 1'b1;
    wait_addr(8'h03, 20, ok);
    check("reach_addr3", ok, 1);
    sysReset = 1'b1;
    #1;
    check("arst_addr", bus.fofbDSPreadoutAddress, 8'hFF);
    check("arst_active", bus.sweepActive, 0);
    check("arst_done", bus.sweepDone, 0);
    check("arst_count", bus.presentCount, 0);
    tick(1);
    sysReset = 1'b0;
    mon_clear();
    tick(8);
    check("post_rst_no_done", done_cnt, 0);
    check("post_rst_parked", addr_seq.size(), 1);
    check("post_rst_csr", bus.csr, 0);
    bus.readoutValid = 1'b0;
    rand_pat();
    run_sweep(7, 7, 1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
